// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency request/ack handshake and byte-lane stores.
// A request is captured in IDLE, answered LAT cycles later, and any store commits on the edge leaving RESP.
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              stall
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'((LAT > 0) ? LAT - 1 : 0);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              ack_q;
    logic              err_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              enter_resp_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_we_d;
    logic [3:0]        rd_be_d;
    logic              wr_en_d;

    function automatic logic is_legal(input logic [3:0] b);
        return b inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                         4'b0011, 4'b1100, 4'b1111};
    endfunction

    // With LAT=0 the response is entered straight from IDLE, so the live request fields are used.
    always_comb begin
        enter_resp_d = 1'b0;
        rd_addr_d    = addr_q;
        rd_we_d      = we_q;
        rd_be_d      = be_q;
        if (state_q == IDLE) begin
            rd_addr_d    = addr;
            rd_we_d      = we;
            rd_be_d      = be;
            enter_resp_d = req && (LAT == 0);
        end else if (state_q == WAIT) begin
            enter_resp_d = (cnt_q == '0);
        end
    end

    assign wr_en_d = (state_q == RESP) && we_q && is_legal(be_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (enter_resp_d) begin
                ack_q   <= 1'b1;
                err_q   <= rd_we_d && !is_legal(rd_be_d);
                rdata_q <= mem[rd_addr_d];
            end
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        be_q    <= be;
                        wdata_q <= wdata;
                        if (LAT == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Not reset: contents survive rst, and an aborted transaction never reaches RESP.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign stall = ((state_q == IDLE) && req) || (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LAT=2 and a LAT=0 instance checked every cycle against a
// transaction-level model, plus directed scenarios with hand-computed expectations.
module tb_data_mem_responder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_s   [2];
    logic          we_s    [2];
    logic [AW-1:0] addr_s  [2];
    logic [3:0]    be_s    [2];
    logic [31:0]   wdata_s [2];
    logic [31:0]   rdata_o [2];
    logic          ack_o   [2];
    logic          err_o   [2];
    logic          stall_o [2];

    data_mem_responder #(.ADDR_W(AW), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .be(be_s[0]), .wdata(wdata_s[0]), .rdata(rdata_o[0]), .ack(ack_o[0]),
        .err(err_o[0]), .stall(stall_o[0])
    );

    data_mem_responder #(.ADDR_W(AW), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .be(be_s[1]), .wdata(wdata_s[1]), .rdata(rdata_o[1]), .ack(ack_o[1]),
        .err(err_o[1]), .stall(stall_o[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Byte enables are legal when empty, a single byte, an aligned halfword, or the full word.
    function automatic bit legal(input logic [3:0] b);
        return ($countones(b) <= 1) || (b == 4'b0011) || (b == 4'b1100) || (b == 4'b1111);
    endfunction

    function automatic int key(input int k, input logic [AW-1:0] a);
        return k * (1 << AW) + int'(a);
    endfunction

    logic [31:0] mm [int];
    bit          pend  [2] = '{1'b0, 1'b0};
    int          acc   [2];
    logic        mwe   [2];
    logic [AW-1:0] maddr [2];
    logic [3:0]  mbe   [2];
    logic [31:0] mwd   [2];
    logic [31:0] held  [2] = '{32'h0, 32'h0};
    bit          held_known [2] = '{1'b1, 1'b1};

    int          a0_cyc [$];
    logic [31:0] a0_dat [$];
    logic        a0_err [$];
    int          a1_cyc [$];
    logic [31:0] a1_dat [$];
    logic        a1_err [$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        e_ack, e_err, e_stall, known;
            logic [31:0] e_rd, w;
            int          due, kk;
            due   = acc[k] + 1 + lat_of(k);
            e_ack = 1'b0;
            e_err = 1'b0;
            e_rd  = held[k];
            known = held_known[k];
            if (!rst) begin
                e_stall = req_s[k];
                e_rd    = 32'h0;
                known   = 1'b1;
            end else if (pend[k]) begin
                e_ack   = (cyc == due);
                e_stall = (cyc <= acc[k] + lat_of(k));
                e_err   = e_ack && mwe[k] && !legal(mbe[k]);
                if (e_ack) begin
                    kk    = key(k, maddr[k]);
                    known = mm.exists(kk);
                    e_rd  = known ? mm[kk] : 32'h0;
                end
            end else begin
                e_stall = req_s[k];
            end

            chk($sformatf("stall%0d", k), 32'(stall_o[k]), 32'(e_stall));
            chk($sformatf("ack%0d", k),   32'(ack_o[k]),   32'(e_ack));
            chk($sformatf("err%0d", k),   32'(err_o[k]),   32'(e_err));
            if (known) chk($sformatf("rdata%0d", k), rdata_o[k], e_rd);

            if (ack_o[k] === 1'b1) begin
                if (k == 0) begin a0_cyc.push_back(cyc); a0_dat.push_back(rdata_o[k]); a0_err.push_back(err_o[k]); end
                else        begin a1_cyc.push_back(cyc); a1_dat.push_back(rdata_o[k]); a1_err.push_back(err_o[k]); end
            end

            if (!rst) begin
                pend[k]       = 1'b0;
                held[k]       = 32'h0;
                held_known[k] = 1'b1;
            end else if (pend[k]) begin
                if (cyc == due) begin
                    held[k]       = e_rd;
                    held_known[k] = known;
                    if (mwe[k] && legal(mbe[k])) begin
                        kk = key(k, maddr[k]);
                        if (mbe[k] == 4'hF) begin
                            mm[kk] = mwd[k];
                        end else if (mm.exists(kk)) begin
                            w = mm[kk];
                            for (int b = 0; b < 4; b++)
                                if (mbe[k][b]) w[8*b +: 8] = mwd[k][8*b +: 8];
                            mm[kk] = w;
                        end
                    end
                    pend[k] = 1'b0;
                end
            end else if (req_s[k]) begin
                pend[k]  = 1'b1;
                acc[k]   = cyc;
                mwe[k]   = we_s[k];
                maddr[k] = addr_s[k];
                mbe[k]   = be_s[k];
                mwd[k]   = wdata_s[k];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        int t0;
        bit got;
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; be_s[k] = b; wdata_s[k] = d;
        t0 = cyc;
        tick(1);
        req_s[k] = 1'b0;
        tick(5);
        got = (k == 0) ? (a0_cyc.size() != 0) : (a1_cyc.size() != 0);
        chk($sformatf("ack_seen%0d", k), 32'(got), 32'd1);
        lat = -1; rd = 32'h0; er = 1'b0;
        if (got) begin
            if (k == 0) begin lat = a0_cyc.pop_front() - t0; rd = a0_dat.pop_front(); er = a0_err.pop_front(); end
            else        begin lat = a1_cyc.pop_front() - t0; rd = a1_dat.pop_front(); er = a1_err.pop_front(); end
        end
    endtask

    initial begin
        int          lat, t0;
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_d [3];
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; be_s[k] = '0; wdata_s[k] = '0;
        end
        tick(3);
        req_s[0] = 1'b1;
        tick(1);
        req_s[0] = 1'b0;
        rst = 1'b1;
        tick(1);

        do_req(0, 1'b1, 10'd1, 4'hF, 32'h11111111, lat, rd, er);
        do_req(0, 1'b1, 10'd2, 4'hF, 32'h22222222, lat, rd, er);
        do_req(0, 1'b1, 10'd3, 4'hF, 32'h33333333, lat, rd, er);
        do_req(0, 1'b1, 10'd7, 4'hF, 32'h11223344, lat, rd, er);

        do_req(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, lat, rd, er);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 10'd5, 4'hF, 32'h0, lat, rd, er);
        chk("ld_lat", 32'(lat), 32'd3);
        chk("ld_dead", rd, 32'hDEADBEEF);
        chk("ld_err", 32'(er), 32'd0);

        do_req(0, 1'b1, 10'd5, 4'b0010, 32'h00005A00, lat, rd, er);
        chk("st_preword", rd, 32'hDEADBEEF);
        do_req(0, 1'b0, 10'd5, 4'hF, 32'h0, lat, rd, er);
        chk("ld_lane1", rd, 32'hDEAD5AEF);
        chk("model_w5", mm[key(0, 10'd5)], 32'hDEAD5AEF);

        do_req(0, 1'b1, 10'd7, 4'b0101, 32'hFFFFFFFF, lat, rd, er);
        chk("bad_be_err", 32'(er), 32'd1);
        chk("bad_be_lat", 32'(lat), 32'd3);
        do_req(0, 1'b0, 10'd7, 4'hF, 32'h0, lat, rd, er);
        chk("bad_be_keep", rd, 32'h11223344);

        do_req(0, 1'b1, 10'd1, 4'b0000, 32'hFFFFFFFF, lat, rd, er);
        chk("be0_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 10'd1, 4'hF, 32'h0, lat, rd, er);
        chk("be0_keep", rd, 32'h11111111);

        do_req(0, 1'b1, 10'd2, 4'b1100, 32'hABCD0000, lat, rd, er);
        do_req(0, 1'b0, 10'd2, 4'b0101, 32'h0, lat, rd, er);
        chk("hi_half", rd, 32'hABCD2222);
        chk("ld_ignores_be", 32'(er), 32'd0);

        exp_d[0] = 32'h11111111; exp_d[1] = 32'hABCD2222; exp_d[2] = 32'h33333333;
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 10'd1; be_s[0] = 4'h0;
        t0 = cyc;
        tick(4); addr_s[0] = 10'd2;
        tick(4); addr_s[0] = 10'd3;
        tick(4); req_s[0] = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            if (a0_cyc.size() == 0) begin
                chk($sformatf("burst_ack%0d_seen", i), 32'd0, 32'd1);
            end else begin
                chk($sformatf("burst_ack%0d_cyc", i), 32'(a0_cyc.pop_front() - t0), 32'(3 + 4 * i));
                chk($sformatf("burst_ack%0d_dat", i), a0_dat.pop_front(), exp_d[i]);
                void'(a0_err.pop_front());
            end
        end

        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 10'd3; be_s[0] = 4'hF; wdata_s[0] = 32'hAAAAAAAA;
        tick(1);
        req_s[0] = 1'b0;
        rst = 1'b0;
        tick(1);
        chk("rst_rdata", rdata_o[0], 32'h0);
        rst = 1'b1;
        tick(5);
        chk("rst_noack", 32'(a0_cyc.size()), 32'd0);
        do_req(0, 1'b0, 10'd3, 4'hF, 32'h0, lat, rd, er);
        chk("rst_keep", rd, 32'h33333333);
        chk("rst_next_lat", 32'(lat), 32'd3);

        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 10'd9; be_s[1] = 4'hF; wdata_s[1] = 32'h0BADF00D;
        t0 = cyc;
        #1;
        chk("lat0_stall_T", 32'(stall_o[1]), 32'd1);
        tick(1);
        chk("lat0_ack_T1", 32'(ack_o[1]), 32'd1);
        chk("lat0_stall_T1", 32'(stall_o[1]), 32'd0);
        we_s[1] = 1'b0;
        tick(2);
        req_s[1] = 1'b0;
        tick(2);
        chk("b2b_count", 32'(a1_cyc.size()), 32'd2);
        if (a1_cyc.size() == 2) begin
            chk("b2b_st_cyc", 32'(a1_cyc[0] - t0), 32'd1);
            chk("b2b_ld_cyc", 32'(a1_cyc[1] - t0), 32'd3);
            chk("b2b_ld_dat", a1_dat[1], 32'h0BADF00D);
        end
        a1_cyc.delete(); a1_dat.delete(); a1_err.delete();
        do_req(1, 1'b0, 10'd9, 4'hF, 32'h0, lat, rd, er);
        chk("lat0_lat", 32'(lat), 32'd1);
        chk("lat0_dat", rd, 32'h0BADF00D);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; storage depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter LAT, default 2, range 0..15, meaning wait cycles between request acceptance and response.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port req, input, 1 bit, meaning a CPU memory request is present.
REQ-006 SHALL have port we, input, 1 bit, meaning 1 = store, 0 = load.
REQ-007 SHALL have port addr, input, ADDR_W bits, meaning word address (byte address bits [ADDR_W+1:2]).
REQ-008 SHALL have port be, input, 4 bits, meaning byte-lane enables for stores; be[0] is bits 7:0.
REQ-009 SHALL have port wdata, input, 32 bits, meaning store data.
REQ-010 SHALL have port rdata, output, 32 bits, meaning load data; registered.
REQ-011 SHALL have port ack, output, 1 bit, meaning the response cycle; registered.
REQ-012 SHALL have port err, output, 1 bit, meaning the store was rejected; valid only while ack=1.
REQ-013 SHALL have port stall, output, 1 bit, meaning the CPU shall hold its pipeline; combinational.

Function
REQ-014 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1 at edge T, SHALL capture addr/we/be/wdata and go to WAIT (LAT>0, counter loaded with LAT-1) or RESP (LAT=0).
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0; ack=1 is therefore exactly in cycle T+1+LAT.
REQ-017 RESP SHALL last exactly one cycle with ack=1, then return to IDLE regardless of req.
REQ-018 stall SHALL be 1 when (state=IDLE and req=1) or state=WAIT, and 0 otherwise; stall=0 in the RESP cycle.
REQ-019 req, addr, we, be and wdata SHALL be ignored in WAIT and RESP; the minimum spacing between accepted requests is LAT+2 cycles.
REQ-020 On the edge entering RESP, SHALL load rdata with mem[captured addr] for both loads and stores; a store returns the pre-write word.
REQ-021 rdata SHALL hold its value until the next RESP entry.
REQ-022 A legal store SHALL write only the enabled byte lanes of the captured wdata on the edge leaving RESP.
REQ-023 Legal be patterns SHALL be 0001, 0010, 0100, 1000, 0011, 1100 and 1111; be=0000 is legal and writes nothing.
REQ-024 A store with any other be SHALL write nothing and assert err=1 with ack; loads SHALL ignore be and never assert err.
REQ-025 err SHALL be 0 whenever ack=0.
REQ-026 A store immediately followed by a load of the same address SHALL return the newly written data.

Reset
REQ-027 While rst=0, SHALL force state=IDLE, counter=0, ack=0, err=0 and rdata=0; stall then follows REQ-018 from req.
REQ-028 Reset asserted during WAIT or RESP SHALL abort the transaction: no write occurs and no ack is produced.
REQ-029 Memory contents SHALL NOT be affected by reset; their power-up value is undefined.
REQ-030 The first request SHALL be accepted at the first rising edge with rst=1 and req=1.

Verification
REQ-031 LAT=2: store addr=5, be=1111, wdata=DEADBEEF at T, then load addr=5 -> store ack at T+3 with stall=1 at T..T+2; load ack returns rdata=DEADBEEF, err=0.
REQ-032 Store addr=5, be=0010, wdata=00005A00 over word DEADBEEF, then load -> rdata=DEAD5AEF.
REQ-033 Store be=0101 to a word holding 11223344 -> ack=1, err=1, word unchanged on reload.
REQ-034 Hold req=1 continuously with loads to addr 1, 2 and 3, LAT=2 -> acks at T+3, T+7 and T+11, each returning the correct word.
REQ-035 Drive rst=0 one cycle after accepting a store -> ack stays 0, rdata=0, the target word is unchanged, and the next request completes normally.
REQ-036 LAT=0: load at T -> ack at T+1 and stall=1 only at T.
